// File: rtl/capture_trigger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : capture_trigger_pkg
// Description : Shared types and constants for the capture trigger block:
//               FSM state encoding, CSR word addresses, CTRL bit positions
//               and K28.5 start-of-frame match defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package capture_trigger_pkg;

    // Snooped word: [35:32] K-char flags, [31:0] data
    localparam int WORD_W = 36;

    // Capture FSM states; encoding is software visible through CTRL[1:0]
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // CSR word addresses
    localparam logic [3:0] C_ADDR_CTRL     = 4'd0;
    localparam logic [3:0] C_ADDR_MATCH_LO = 4'd1;
    localparam logic [3:0] C_ADDR_MATCH_HI = 4'd2;
    localparam logic [3:0] C_ADDR_MASK_LO  = 4'd3;
    localparam logic [3:0] C_ADDR_MASK_HI  = 4'd4;
    localparam logic [3:0] C_ADDR_LEN      = 4'd5;
    localparam logic [3:0] C_ADDR_EMITTED  = 4'd6;

    // CTRL write command bits (self-clearing strobes)
    localparam int C_CTRL_ARM_BIT   = 0;
    localparam int C_CTRL_ABORT_BIT = 1;

    // K28.5 start-of-frame: data byte 0xBC with the lane-0 K flag (bit 32)
    localparam logic [7:0]        C_K28_5      = 8'hBC;
    localparam int                C_SOF_K_BIT  = 32;
    localparam logic [WORD_W-1:0] C_SOF_MATCH  = 36'h1_0000_00BC;
    localparam logic [WORD_W-1:0] C_SOF_MASK   = 36'h1_0000_00FF;

endpackage
`default_nettype wire

// File: rtl/capture_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : capture_delay_line
// Description : PRE_WORDS-deep shift register of {tag, word}. Advances one
//               slot per shift strobe; the oldest entry is presented on the
//               out_* ports and leaves on the next shift. Tags can be cleared
//               synchronously without disturbing the data.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_delay_line
    import capture_trigger_pkg::*;
#(
    parameter int PRE_WORDS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              shift,
    input  logic              clear_tags,
    input  logic              in_tag,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_tag,
    output logic [WORD_W-1:0] out_word
);

    logic [WORD_W-1:0]    r_word [PRE_WORDS];
    logic [PRE_WORDS-1:0] r_tag;

    // Tag chain: clear wins over shift so an arm/abort beat never leaves a live tag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tag <= '0;
        end else if (clear_tags) begin
            r_tag <= '0;
        end else if (shift) begin
            for (int i = PRE_WORDS - 1; i > 0; i--) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_tag[0] <= in_tag;
        end
    end

    // Data chain: shifts on every valid beat, contents meaningless without a tag
    always_ff @(posedge clk) begin
        if (shift) begin
            for (int i = PRE_WORDS - 1; i > 0; i--) begin
                r_word[i] <= r_word[i-1];
            end
            r_word[0] <= in_word;
        end
    end

    assign out_tag  = r_tag[PRE_WORDS-1];
    assign out_word = r_word[PRE_WORDS-1];

endmodule
`default_nettype wire

// File: rtl/capture_trigger.sv
`default_nettype none
// ============================================================================
// Module      : capture_trigger
// Description : Masked-match trigger in front of stream_capture. Once armed,
//               tags every snooped beat into a pre-trigger delay line; on a
//               match it forwards up to PRE_WORDS history words, the trigger
//               word and the following words, LEN words in total.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_trigger
    import capture_trigger_pkg::*;
#(
    parameter int PRE_WORDS   = 8,
    parameter int LEN_W       = 20,
    parameter int DEFAULT_LEN = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic [3:0]        csr_address,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              triggered
);

    state_t             r_state, w_state_next;
    logic [31:0]        r_match_lo, r_mask_lo;
    logic [3:0]         r_match_hi, r_mask_hi;
    logic [WORD_W-1:0]  r_match_act, r_mask_act;
    logic [LEN_W-1:0]   r_len, r_cnt, w_cnt_next, r_emitted;
    logic               r_out_valid, r_triggered;
    logic [WORD_W-1:0]  r_out_data;
    logic [31:0]        r_readdata, w_readdata;
    logic               w_ctrl_wr, w_arm, w_abort, w_hit, w_live_exit;
    logic               w_emit, w_clear_tags, w_accept_arm, w_fire, w_in_tag;
    logic               w_dl_tag;
    logic [WORD_W-1:0]  w_dl_word;

    assign w_ctrl_wr   = csr_write && (csr_address == C_ADDR_CTRL);
    assign w_arm       = w_ctrl_wr && csr_writedata[C_CTRL_ARM_BIT];
    assign w_abort     = w_ctrl_wr && csr_writedata[C_CTRL_ABORT_BIT];
    // Match uses the MATCH/MASK snapshot taken at arm time
    assign w_hit       = in_valid && (((in_data ^ r_match_act) & r_mask_act) == '0);
    assign w_live_exit = in_valid && w_dl_tag;
    assign w_in_tag    = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);

    capture_delay_line #(
        .PRE_WORDS (PRE_WORDS)
    ) u_delay (
        .clk        (clk),
        .reset_n    (reset_n),
        .shift      (in_valid),
        .clear_tags (w_clear_tags),
        .in_tag     (w_in_tag),
        .in_word    (in_data),
        .out_tag    (w_dl_tag),
        .out_word   (w_dl_word)
    );

    // Next-state and window-counter logic; the match beat itself already emits
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_emit       = 1'b0;
        w_clear_tags = 1'b0;
        w_accept_arm = 1'b0;
        w_fire       = 1'b0;
        if (w_abort) begin
            w_state_next = ST_IDLE;
            w_clear_tags = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_arm) begin
                        w_state_next = ST_ARMED;
                        w_clear_tags = 1'b1;
                        w_accept_arm = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_hit) begin
                        w_fire = 1'b1;
                        if (r_len == '0) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_emit       = w_live_exit;
                            w_cnt_next   = r_len - LEN_W'(w_live_exit);
                            w_state_next = (w_cnt_next == '0) ? ST_DONE : ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    w_emit     = w_live_exit;
                    w_cnt_next = r_cnt - LEN_W'(w_live_exit);
                    if (w_cnt_next == '0) begin
                        w_state_next = ST_DONE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Software-visible configuration registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_match_lo <= '0;
            r_match_hi <= '0;
            r_mask_lo  <= '0;
            r_mask_hi  <= '0;
            r_len      <= LEN_W'(DEFAULT_LEN);
        end else if (csr_write) begin
            case (csr_address)
                C_ADDR_MATCH_LO: r_match_lo <= csr_writedata;
                C_ADDR_MATCH_HI: r_match_hi <= csr_writedata[3:0];
                C_ADDR_MASK_LO:  r_mask_lo  <= csr_writedata;
                C_ADDR_MASK_HI:  r_mask_hi  <= csr_writedata[3:0];
                C_ADDR_LEN:      r_len      <= csr_writedata[LEN_W-1:0];
                default: ;
            endcase
        end
    end

    // Capture datapath: snapshot, window counter, output register, status
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_match_act <= '0;
            r_mask_act  <= '0;
            r_cnt       <= '0;
            r_emitted   <= '0;
            r_triggered <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_data <= w_dl_word;
            end
            if (w_accept_arm) begin
                r_match_act <= {r_match_hi, r_match_lo};
                r_mask_act  <= {r_mask_hi, r_mask_lo};
            end
            if (w_accept_arm) begin
                r_emitted <= '0;
            end else if (w_emit && (r_emitted != '1)) begin
                r_emitted <= r_emitted + LEN_W'(1);
            end
            if (w_abort || w_accept_arm) begin
                r_triggered <= 1'b0;
            end else if (w_fire) begin
                r_triggered <= 1'b1;
            end
        end
    end

    // CSR read mux
    always_comb begin
        w_readdata = '0;
        case (csr_address)
            C_ADDR_CTRL:     w_readdata = {30'd0, r_state};
            C_ADDR_MATCH_LO: w_readdata = r_match_lo;
            C_ADDR_MATCH_HI: w_readdata = {28'd0, r_match_hi};
            C_ADDR_MASK_LO:  w_readdata = r_mask_lo;
            C_ADDR_MASK_HI:  w_readdata = {28'd0, r_mask_hi};
            C_ADDR_LEN:      w_readdata = 32'(r_len);
            C_ADDR_EMITTED:  w_readdata = 32'(r_emitted);
            default:         w_readdata = '0;
        endcase
    end

    // Registered read data, one-cycle latency, zero when not reading
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= csr_read ? w_readdata : 32'd0;
        end
    end

    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign csr_readdata = r_readdata;
    assign triggered    = r_triggered;

endmodule
`default_nettype wire

// File: tb/tb_capture_trigger.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_trigger
// Description : Self-checking bench for capture_trigger: CSR vector table,
//               directed window scenarios and randomized windows checked
//               against a sequence-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_trigger;
    import capture_trigger_pkg::*;

    localparam int PRE = 4;
    localparam int LW  = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [35:0] in_data;
    logic        in_valid;
    logic [35:0] out_data;
    logic        out_valid;
    logic [3:0]  csr_address;
    logic        csr_write;
    logic        csr_read;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        triggered;

    int total = 0;
    int bad   = 0;
    logic [35:0] got[$];

    always #5 clk = ~clk;

    capture_trigger #(
        .PRE_WORDS   (PRE),
        .LEN_W       (LW),
        .DEFAULT_LEN (1024)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .csr_address   (csr_address),
        .csr_write     (csr_write),
        .csr_read      (csr_read),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .triggered     (triggered)
    );

    // Output monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (out_valid) got.push_back(out_data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [35:0] d, input logic w,
                       input logic [3:0] a, input logic [31:0] wd);
        in_valid = v; in_data = d; csr_write = w; csr_address = a; csr_writedata = wd;
        @(negedge clk);
        in_valid = 1'b0; csr_write = 1'b0;
    endtask

    task automatic feed(input logic [35:0] d);
        cyc(1'b1, d, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 36'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b0, 36'd0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic setup(input logic [35:0] m, input logic [35:0] k, input int len);
        wr(C_ADDR_MATCH_LO, m[31:0]);
        wr(C_ADDR_MATCH_HI, {28'd0, m[35:32]});
        wr(C_ADDR_MASK_LO,  k[31:0]);
        wr(C_ADDR_MASK_HI,  {28'd0, k[35:32]});
        wr(C_ADDR_LEN, 32'(len));
    endtask

    task automatic arm();
        got.delete();
        wr(C_ADDR_CTRL, 32'h1);
    endtask

    task automatic cmp_q(input string name, input logic [35:0] exp[$]);
        check({name, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size()) check(name, 64'(got[i]), 64'(exp[i]));
    endtask

    task automatic check_status(input string name, input int st, input int em, input logic tr);
        logic [31:0] v;
        rd(C_ADDR_CTRL, v);
        check({name, "_state"}, 64'(v), 64'(st));
        rd(C_ADDR_EMITTED, v);
        check({name, "_emitted"}, 64'(v), 64'(em));
        check({name, "_triggered"}, 64'(triggered), 64'(tr));
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } csr_vec_t;

    localparam logic [35:0] TRIG = 36'h1_1234_56BC;

    initial begin
        csr_vec_t    tbl[9];
        logic [31:0] v;
        logic [35:0] eq[$];
        logic [35:0] hist[$];
        logic [35:0] m, k, w;
        int          len, kidx, start;

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; csr_write = 1'b0;
        csr_read = 1'b0; csr_address = '0; csr_writedata = '0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_readdata", 64'(csr_readdata), 64'd0);
        check("rst_triggered", 64'(triggered), 64'd0);
        rd(C_ADDR_LEN, v);
        check("rst_len", 64'(v), 64'd1024);
        check_status("rst", 0, 0, 1'b0);

        // CSR write/readback table, including width masking and unmapped words
        tbl[0] = '{C_ADDR_MATCH_LO, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[1] = '{C_ADDR_MATCH_HI, 32'hFFFF_FFFF, 32'h0000_000F};
        tbl[2] = '{C_ADDR_MASK_LO,  32'h1234_5678, 32'h1234_5678};
        tbl[3] = '{C_ADDR_MASK_HI,  32'h0000_00A5, 32'h0000_0005};
        tbl[4] = '{C_ADDR_LEN,      32'hFFFF_FFFF, 32'h000F_FFFF};
        tbl[5] = '{C_ADDR_EMITTED,  32'h0000_0055, 32'h0000_0000};
        tbl[6] = '{4'd7,            32'h0000_1234, 32'h0000_0000};
        tbl[7] = '{4'd15,           32'hFFFF_FFFF, 32'h0000_0000};
        tbl[8] = '{C_ADDR_CTRL,     32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 9; i++) begin
            wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, v);
            check($sformatf("csr_tbl%0d", i), 64'(v), 64'(tbl[i].exp));
        end

        // Pre-trigger window with latency check
        setup(C_SOF_MATCH, C_SOF_MASK, 8);
        arm();
        for (int i = 1; i <= 10; i++) feed(36'(i));
        feed(TRIG);
        feed(36'h20); feed(36'h21); feed(36'h22);
        check("t1_pre_count", 64'(got.size()), 64'd4);
        feed(36'h23);
        check("t1_trig_latency", 64'(got.size()), 64'd5);
        for (int i = 36'h24; i <= 36'h2F; i++) feed(36'(i));
        eq = {36'h7, 36'h8, 36'h9, 36'hA, TRIG, 36'h20, 36'h21, 36'h22};
        cmp_q("t1", eq);
        check_status("t1", 3, 8, 1'b1);

        // Zero length: fires, emits nothing, leaves tagged words in the line
        wr(C_ADDR_LEN, 32'd0);
        arm();
        feed(36'h11); feed(36'h12); feed(36'h13); feed(TRIG);
        idle(3);
        check("zero_len_outputs", 64'(got.size()), 64'd0);
        check_status("zero", 3, 0, 1'b1);

        // Short pre-history straight from DONE: stale tagged words must not leak
        wr(C_ADDR_LEN, 32'd5);
        arm();
        feed(36'h100); feed(36'h101); feed(TRIG);
        for (int i = 0; i < 6; i++) feed(36'h200 + 36'(i));
        eq = {36'h100, 36'h101, TRIG, 36'h200, 36'h201};
        cmp_q("short", eq);
        check_status("short", 3, 5, 1'b1);

        // Abort mid-window with a valid beat on the abort cycle
        setup(36'd0, 36'd0, 100);
        arm();
        for (int i = 0; i < 40; i++) begin
            feed(36'h300 + 36'(i));
            if (got.size() >= 10) break;
        end
        cyc(1'b1, 36'h3FF, 1'b1, C_ADDR_CTRL, 32'h2);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        idle(2);
        check("abort_outputs", 64'(got.size()), 64'd10);
        if (got.size() >= 10) begin
            check("abort_first", 64'(got[0]), 64'h300);
            check("abort_last", 64'(got[9]), 64'h309);
        end
        check_status("abort", 0, 10, 1'b0);

        // Arm and abort together: abort wins
        wr(C_ADDR_CTRL, 32'h3);
        rd(C_ADDR_CTRL, v);
        check("arm_abort_state", 64'(v), 64'd0);

        // Arm during CAPTURE is ignored
        setup(36'd0, 36'd0, 6);
        arm();
        for (int i = 0; i < 6; i++) feed(36'h400 + 36'(i));
        cyc(1'b1, 36'h406, 1'b1, C_ADDR_CTRL, 32'h1);
        for (int i = 7; i < 13; i++) feed(36'h400 + 36'(i));
        eq = {36'h400, 36'h401, 36'h402, 36'h403, 36'h404, 36'h405};
        cmp_q("rearm", eq);
        check_status("rearm", 3, 6, 1'b1);

        // Reset mid-capture
        setup(36'h0_CAFE_0000, 36'd0, 50);
        arm();
        for (int i = 0; i < 8; i++) feed(36'h500 + 36'(i));
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_out_data", 64'(out_data), 64'd0);
        check("mrst_triggered", 64'(triggered), 64'd0);
        rd(C_ADDR_CTRL, v);
        check("mrst_ctrl", 64'(v), 64'd0);
        rd(C_ADDR_LEN, v);
        check("mrst_len", 64'(v), 64'd1024);
        rd(C_ADDR_MATCH_LO, v);
        check("mrst_match_lo", 64'(v), 64'd0);
        rd(C_ADDR_EMITTED, v);
        check("mrst_emitted", 64'(v), 64'd0);

        // Randomized windows against a sequence-level model
        for (int it = 0; it < 25; it++) begin
            wr(C_ADDR_CTRL, 32'h2);
            for (int j = 0; j < 3; j++) feed({4'($urandom_range(0, 15)), $urandom()});
            m = {4'($urandom_range(0, 15)), $urandom()};
            k = '0;
            k[3:0] = 4'($urandom_range(0, 15));
            k[32]  = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 12);
            setup(m, k, len);
            arm();
            hist.delete();
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(0, 9) < 7) begin
                    w = {4'($urandom_range(0, 15)), $urandom()};
                    feed(w);
                    hist.push_back(w);
                end else begin
                    idle(1);
                end
            end
            // Model: first matching word after arm, then the emitted slice of history
            kidx = -1;
            for (int j = 0; j < hist.size(); j++)
                if (kidx < 0 && ((hist[j] ^ m) & k) == 36'd0) kidx = j;
            eq.delete();
            if (kidx >= 0 && len > 0) begin
                start = (kidx > PRE) ? kidx - PRE : 0;
                for (int j = start; (j + PRE < hist.size()) && (eq.size() < len); j++)
                    eq.push_back(hist[j]);
            end
            cmp_q($sformatf("rand%0d", it), eq);
            check_status($sformatf("rand%0d", it),
                         (kidx < 0) ? 1 : ((len == 0 || eq.size() == len) ? 3 : 2),
                         eq.size(), kidx >= 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
